// File: rtl/fetch_ctl.sv
// Fetch-side control: decodes JMP/BRZ/WAIT/HALT and drives the PC redirect inputs.
// Build option: define FETCH_CTL_WAIT_EN to include the counted WAIT stall.
module fetch_ctl (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [15:0] instr_i,
   input  logic        flag_z_i,
   output logic        jump_o,
   output logic        branch_o,
   output logic [7:0]  displacement_o,
   output logic [15:0] jump_tgt_o,
   output logic [15:0] instr_o,
   output logic        valid_o,
   output logic        halted_o
);

   localparam logic [3:0] OP_BRZ  = 4'hB;
   localparam logic [3:0] OP_JMP  = 4'hE;
   localparam logic [3:0] OP_HALT = 4'hF;
`ifdef FETCH_CTL_WAIT_EN
   localparam logic [3:0] OP_WAIT = 4'hA;

   typedef enum logic [1:0] {S_RUN, S_TGT, S_WAIT, S_HALT} state_e;
`else
   typedef enum logic [1:0] {S_RUN, S_TGT, S_HALT} state_e;
`endif

   state_e state_q, state_d;
`ifdef FETCH_CTL_WAIT_EN
   logic [7:0] cnt_q, cnt_d;
`endif

   logic [3:0] opcode;
   logic [7:0] imm8;

   assign opcode = instr_i[15:12];
   assign imm8   = instr_i[7:0];

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_RUN;
`ifdef FETCH_CTL_WAIT_EN
         cnt_q   <= 8'h00;
`endif
      end else begin
         state_q <= state_d;
`ifdef FETCH_CTL_WAIT_EN
         cnt_q   <= cnt_d;
`endif
      end
   end

   // NOTE: every signal written here gets a default first, so no path can infer a latch.
   always_comb begin
      state_d        = state_q;
`ifdef FETCH_CTL_WAIT_EN
      cnt_d          = cnt_q;
`endif
      jump_o         = 1'b0;
      branch_o       = 1'b0;
      displacement_o = 8'h00;
      jump_tgt_o     = 16'h0000;
      valid_o        = 1'b0;
      halted_o       = 1'b0;
      instr_o        = instr_i;

      unique case (state_q)
         S_RUN: begin
            valid_o = 1'b1;
            unique case (opcode)
               OP_BRZ: begin
                  branch_o       = flag_z_i;
                  displacement_o = imm8;
               end
               OP_JMP: begin
                  // Let the PC step onto the target word; it is loaded next cycle.
                  valid_o = 1'b0;
                  state_d = S_TGT;
               end
               OP_HALT: begin
                  branch_o = 1'b1;
                  state_d  = S_HALT;
               end
`ifdef FETCH_CTL_WAIT_EN
               OP_WAIT: begin
                  if (imm8 != 8'h00) begin
                     branch_o = 1'b1;
                     cnt_d    = imm8;
                     state_d  = S_WAIT;
                  end
               end
`endif
               default: ;
            endcase
         end
         S_TGT: begin
            jump_o     = 1'b1;
            jump_tgt_o = instr_i;
            state_d    = S_RUN;
         end
`ifdef FETCH_CTL_WAIT_EN
         S_WAIT: begin
            cnt_d = cnt_q - 8'd1;
            if (cnt_q != 8'd1) begin
               branch_o = 1'b1;
            end else begin
               state_d = S_RUN;
            end
         end
`endif
         S_HALT: begin
            branch_o = 1'b1;
            halted_o = 1'b1;
         end
         default: state_d = S_RUN;
      endcase

      // Outputs are silenced for the whole reset pulse, not just at the edge.
      if (!rst_ni) begin
         jump_o         = 1'b0;
         branch_o       = 1'b0;
         displacement_o = 8'h00;
         jump_tgt_o     = 16'h0000;
         valid_o        = 1'b0;
         halted_o       = 1'b0;
         instr_o        = 16'h0000;
      end
   end

endmodule

// File: tb/tb_fetch_ctl.sv
// Random-program bench for fetch_ctl: the bench plays PC and instruction memory,
// and a program-level model expands each instruction into its expected cycle trace.
module tb_fetch_ctl;

   logic        clk = 1'b0;
   logic        rst_ni;
   logic [15:0] instr_i;
   logic        flag_z_i;
   logic        jump_o;
   logic        branch_o;
   logic [7:0]  displacement_o;
   logic [15:0] jump_tgt_o;
   logic [15:0] instr_o;
   logic        valid_o;
   logic        halted_o;

   always #5 clk = ~clk;

   fetch_ctl dut (
      .clk_i          (clk),
      .rst_ni         (rst_ni),
      .instr_i        (instr_i),
      .flag_z_i       (flag_z_i),
      .jump_o         (jump_o),
      .branch_o       (branch_o),
      .displacement_o (displacement_o),
      .jump_tgt_o     (jump_tgt_o),
      .instr_o        (instr_o),
      .valid_o        (valid_o),
      .halted_o       (halted_o)
   );

   logic [15:0] mem [0:65535];
   logic [15:0] pc = 16'h0000;

   assign instr_i = mem[pc];

   // Program counter driven by the DUT's redirect outputs.
   always @(posedge clk) begin
      if (rst_ni) begin
         if (jump_o)        pc <= jump_tgt_o;
         else if (branch_o) pc <= pc + {{8{displacement_o[7]}}, displacement_o};
         else               pc <= pc + 16'd1;
      end
   end

   typedef struct {
      logic [15:0] addr;
      bit          flag;
      bit          valid;
      bit          jump;
      bit          branch;
      logic [7:0]  disp;
      logic [15:0] tgt;
      bit          halted;
      bit          rst_after;
   } rec_t;

   rec_t        q[$];
   logic [15:0] model_pc;
   int          n_vec = 0;
   int          n_bad = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic chk_zero(input string tag);
      check(tag, 64'({jump_o, branch_o, displacement_o, jump_tgt_o, valid_o, halted_o, instr_o}),
            64'd0);
   endtask

   function automatic rec_t mk(input logic [15:0] addr);
      rec_t r;
      r.addr      = addr;
      r.flag      = 1'($urandom);
      r.valid     = 1'b0;
      r.jump      = 1'b0;
      r.branch    = 1'b0;
      r.disp      = 8'h00;
      r.tgt       = 16'h0000;
      r.halted    = 1'b0;
      r.rst_after = 1'b0;
      return r;
   endfunction

   function automatic logic [15:0] rand_word();
      int          r  = int'($urandom_range(99));
      logic [11:0] lo = 12'($urandom);
      logic [3:0]  op = 4'($urandom_range(11));
      if (op >= 4'd10) op = op + 4'd2;
      if (r < 55)      return {op, lo};
      else if (r < 72) return {4'hB, lo};
      else if (r < 84) return {4'hA, lo[11:8], 8'($urandom_range(5))};
      else if (r < 98) return {4'hE, lo};
      else             return {4'hF, lo};
   endfunction

   // Expand the instruction at model_pc into one expected record per cycle.
   task automatic expand();
      logic [15:0] a = model_pc;
      logic [15:0] w = mem[a];
      rec_t        r = mk(a);
      rec_t        h;
      int          k;
      r.valid = 1'b1;
      case (w[15:12])
         4'hB: begin
            r.branch = r.flag;
            r.disp   = w[7:0];
            q.push_back(r);
            model_pc = r.flag ? a + {{8{w[7]}}, w[7:0]} : a + 16'd1;
         end
         4'hE: begin
            r.valid = 1'b0;
            q.push_back(r);
            h      = mk(a + 16'd1);
            h.jump = 1'b1;
            h.tgt  = mem[a + 16'd1];
            q.push_back(h);
            model_pc = mem[a + 16'd1];
         end
         4'hF: begin
            r.branch = 1'b1;
            q.push_back(r);
            k = int'($urandom_range(3, 20));
            for (int i = 0; i < k; i++) begin
               h           = mk(a);
               h.branch    = 1'b1;
               h.halted    = 1'b1;
               h.rst_after = (i == k - 1);
               q.push_back(h);
            end
            model_pc = a;
         end
`ifdef FETCH_CTL_WAIT_EN
         4'hA: begin
            if (w[7:0] != 8'h00) begin
               r.branch = 1'b1;
               q.push_back(r);
               for (int i = 1; i < int'(w[7:0]); i++) begin
                  h        = mk(a);
                  h.branch = 1'b1;
                  q.push_back(h);
               end
               q.push_back(mk(a));
            end else begin
               q.push_back(r);
            end
            model_pc = a + 16'd1;
         end
`endif
         default: begin
            q.push_back(r);
            model_pc = a + 16'd1;
         end
      endcase
   endtask

   task automatic do_reset();
      rst_ni = 1'b0;
      #1;
      chk_zero("rst_async");
      @(posedge clk);
      #1;
      chk_zero("rst_hold");
      @(negedge clk);
      rst_ni = 1'b1;
      q.delete();
      model_pc = pc;
   endtask

   initial begin
      rec_t r;
      rst_ni   = 1'b0;
      flag_z_i = 1'b0;
      for (int i = 0; i < 65536; i++) mem[i] = rand_word();
      mem[16'h0000] = 16'h1234;
      mem[16'h0001] = 16'h2000;
      mem[16'h0002] = 16'hE000;
      mem[16'h0003] = 16'h0010;
      mem[16'h000E] = 16'hA003;
      mem[16'h000F] = 16'hE000;
      mem[16'h0010] = 16'hB0FE;
      mem[16'h0011] = 16'hE000;
      mem[16'h0012] = 16'hFFFF;
      mem[16'hFFFF] = 16'hB101;

      #2;
      chk_zero("rst_init");
      @(negedge clk);
      chk_zero("rst_init2");
      rst_ni   = 1'b1;
      model_pc = pc;

      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (q.size() == 0) expand();
         r = q.pop_front();
         flag_z_i = r.flag;
         #1;
         check("addr", 64'(pc), 64'(r.addr));
         check("ctl", 64'({jump_o, branch_o, valid_o, halted_o}),
               64'({r.jump, r.branch, r.valid, r.halted}));
         check("disp", 64'(displacement_o), 64'(r.disp));
         check("tgt", 64'(jump_tgt_o), 64'(r.tgt));
         check("instr", 64'(instr_o), 64'(mem[r.addr]));
         if (r.rst_after || $urandom_range(99) == 0) do_reset();
         else @(negedge clk);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
